alu_muldiv: RTL

Parametrised, handshaked execution unit for the single-cycle RISC-V datapath's next revision: it performs all RV32I ALU operations and adds the RV32M multiply/divide family. Base ops complete in one cycle; multiply and divide run iteratively, one bit per cycle. It sits between the decode/operand-read stage and writeback, with valid/ready on both sides so the core can stall on long operations.

---
 rtl/alu_muldiv.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/alu_muldiv.sv
// Handshaked RV32I ALU plus RV32M multiply/divide. Base ops finish in one cycle;
// multiply/divide iterate one bit per cycle on magnitudes with a final sign fix.
module alu_muldiv #(
    parameter int DATA_WIDTH = 32,
    parameter int SHAMT_W    = $clog2(DATA_WIDTH)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [5:0]            i_alu_op,
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_c,
    output logic                  o_illegal,
    output logic [1:0]            o_state
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [5:0] OP_ADD    = 6'b011001;
    localparam logic [5:0] OP_SUB    = 6'b011011;
    localparam logic [5:0] OP_AND    = 6'b011101;
    localparam logic [5:0] OP_OR     = 6'b011111;
    localparam logic [5:0] OP_XOR    = 6'b100001;
    localparam logic [5:0] OP_SLT    = 6'b100011;
    localparam logic [5:0] OP_SLTU   = 6'b100101;
    localparam logic [5:0] OP_SLL    = 6'b100111;
    localparam logic [5:0] OP_SRL    = 6'b101001;
    localparam logic [5:0] OP_SRA    = 6'b101011;
    localparam logic [5:0] OP_MUL    = 6'b101101;
    localparam logic [5:0] OP_MULH   = 6'b101111;
    localparam logic [5:0] OP_MULHSU = 6'b110001;
    localparam logic [5:0] OP_MULHU  = 6'b110011;
    localparam logic [5:0] OP_DIV    = 6'b110101;
    localparam logic [5:0] OP_DIVU   = 6'b110111;
    localparam logic [5:0] OP_REM    = 6'b111001;
    localparam logic [5:0] OP_REMU   = 6'b111011;

    localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

    logic [1:0]     state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2*W-1:0] acc_q, acc_d;
    logic [W-1:0]   mcand_q, mcand_d;
    logic           is_mul_q, is_mul_d;
    logic           sel_q, sel_d;
    logic           sa_q, sa_d;
    logic           sb_q, sb_d;
    logic [W-1:0]   c_q, c_d;
    logic           ill_q, ill_d;

    logic [SHAMT_W-1:0] shamt;
    logic [W-1:0]   base_res;
    logic           legal, op_mul, op_div, a_sgn, b_sgn, sel;
    logic           sa, sb, div_zero, div_ovf, fast;
    logic [W-1:0]   mag_a, mag_b, fast_res;

    assign shamt = i_b[SHAMT_W-1:0];

    // sel marks "high half" for multiplies and "remainder" for divides.
    always_comb begin
        base_res = '0;
        legal    = 1'b1;
        op_mul   = 1'b0;
        op_div   = 1'b0;
        a_sgn    = 1'b0;
        b_sgn    = 1'b0;
        sel      = 1'b0;
        case (i_alu_op)
            OP_ADD:    base_res = i_a + i_b;
            OP_SUB:    base_res = i_a - i_b;
            OP_AND:    base_res = i_a & i_b;
            OP_OR:     base_res = i_a | i_b;
            OP_XOR:    base_res = i_a ^ i_b;
            OP_SLT:    base_res = {{(W-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
            OP_SLTU:   base_res = {{(W-1){1'b0}}, (i_a < i_b)};
            OP_SLL:    base_res = i_a << shamt;
            OP_SRL:    base_res = i_a >> shamt;
            OP_SRA:    base_res = $unsigned($signed(i_a) >>> shamt);
            OP_MUL:    op_mul = 1'b1;
            OP_MULH:   begin op_mul = 1'b1; a_sgn = 1'b1; b_sgn = 1'b1; sel = 1'b1; end
            OP_MULHSU: begin op_mul = 1'b1; a_sgn = 1'b1; sel = 1'b1; end
            OP_MULHU:  begin op_mul = 1'b1; sel = 1'b1; end
            OP_DIV:    begin op_div = 1'b1; a_sgn = 1'b1; b_sgn = 1'b1; end
            OP_DIVU:   op_div = 1'b1;
            OP_REM:    begin op_div = 1'b1; a_sgn = 1'b1; b_sgn = 1'b1; sel = 1'b1; end
            OP_REMU:   begin op_div = 1'b1; sel = 1'b1; end
            default:   legal = 1'b0;
        endcase
    end

    assign sa       = a_sgn & i_a[W-1];
    assign sb       = b_sgn & i_b[W-1];
    assign mag_a    = sa ? ('0 - i_a) : i_a;
    assign mag_b    = sb ? ('0 - i_b) : i_b;
    assign div_zero = (i_b == '0);
    assign div_ovf  = a_sgn & b_sgn & (i_a == MIN_NEG) & (&i_b);
    assign fast     = op_div & (div_zero | div_ovf);
    assign fast_res = div_zero ? (sel ? i_a : '1) : (sel ? '0 : i_a);

    // One iteration: acc holds {partial product, multiplier} or {remainder, quotient}.
    logic [W:0]     mul_sum, rem_sh, rem_sub;
    logic           quo_bit;
    logic [W-1:0]   rem_new, quo_fix, rem_fix, final_res;
    logic [2*W-1:0] mul_next, div_next, step, prod_fix;

    always_comb begin
        mul_sum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
        mul_next  = {mul_sum, acc_q[W-1:1]};
        rem_sh    = {acc_q[2*W-1:W], acc_q[W-1]};
        rem_sub   = rem_sh - {1'b0, mcand_q};
        quo_bit   = (rem_sh >= {1'b0, mcand_q});
        rem_new   = quo_bit ? rem_sub[W-1:0] : rem_sh[W-1:0];
        div_next  = {rem_new, acc_q[W-2:0], quo_bit};
        step      = is_mul_q ? mul_next : div_next;
        prod_fix  = (sa_q ^ sb_q) ? ('0 - step) : step;
        quo_fix   = (sa_q ^ sb_q) ? ('0 - step[W-1:0]) : step[W-1:0];
        rem_fix   = sa_q ? ('0 - step[2*W-1:W]) : step[2*W-1:W];
        final_res = is_mul_q ? (sel_q ? prod_fix[2*W-1:W] : prod_fix[W-1:0])
                             : (sel_q ? rem_fix : quo_fix);
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        is_mul_d = is_mul_q;
        sel_d    = sel_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        c_d      = c_q;
        ill_d    = ill_q;
        case (state_q)
            S_IDLE: begin
                if (i_valid) begin
                    if ((op_mul | op_div) && !fast) begin
                        state_d  = S_BUSY;
                        cnt_d    = CW'(W);
                        acc_d    = {{W{1'b0}}, (op_mul ? mag_b : mag_a)};
                        mcand_d  = op_mul ? mag_a : mag_b;
                        is_mul_d = op_mul;
                        sel_d    = sel;
                        sa_d     = sa;
                        sb_d     = sb;
                    end else begin
                        state_d = S_DONE;
                        c_d     = fast ? fast_res : base_res;
                        ill_d   = ~legal;
                    end
                end
            end
            S_BUSY: begin
                acc_d = step;
                cnt_d = cnt_q - CW'(1);
                // Last iteration also applies the sign fix and loads the result.
                if (cnt_q == CW'(1)) begin
                    c_d     = final_res;
                    ill_d   = 1'b0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (i_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            is_mul_q <= 1'b0;
            sel_q    <= 1'b0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            c_q      <= '0;
            ill_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            is_mul_q <= is_mul_d;
            sel_q    <= sel_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            c_q      <= c_d;
            ill_q    <= ill_d;
        end
    end

    assign o_ready   = (state_q == S_IDLE);
    assign o_valid   = (state_q == S_DONE);
    assign o_c       = c_q;
    assign o_illegal = ill_q;
    assign o_state   = state_q;

endmodule
